// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encodings and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder cell built from gate-level sum/carry equations.
module FullAdderStructure (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic cout,
    output logic s
);

    logic xy_xor;
    logic xy_and;
    logic carry_prop;

    assign xy_xor     = x ^ y;
    assign xy_and     = x & y;
    assign carry_prop = xy_xor & cin;
    assign s          = xy_xor ^ cin;
    assign cout       = xy_and | carry_prop;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell consumes operand bits LSB first,
// one bit per clock, with a registered carry and a result shift register.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             carry_q,  carry_d;
    logic             cout_q,   cout_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    logic fa_s;
    logic fa_cout;

    FullAdderStructure u_fa (a_sh_q[0], b_sh_q[0], carry_q, fa_cout, fa_s);

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;

        case (state_q)
            // DONE accepts a new start just like IDLE, giving back-to-back operation.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                res_sh_d = {fa_s, res_sh_q[WIDTH-1:1]};
                carry_d  = fa_cout;
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_s, res_sh_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 (vectors, random, corner
// sequences) and WIDTH=2 (exhaustive), against plain a+b+cin arithmetic.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One full 8-bit operation from IDLE; result expected in the cycle after edge N+8.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [7:0] es, input logic ec);
        int cyc;
        logic [7:0] prev;
        logic bad_busy, bad_stab;
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b; cin8 = ci;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        prev = sum8; cyc = 0; bad_busy = 1'b0; bad_stab = 1'b0;
        while (done8 !== 1'b1 && cyc < 40) begin
            if (busy8 !== 1'b1) bad_busy = 1'b1;
            if (sum8 !== prev) bad_stab = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, 8);
        check({tag, "_busy_run"}, bad_busy, 0);
        check({tag, "_sum_stable"}, bad_stab, 0);
        check({tag, "_sum"}, sum8, es);
        check({tag, "_cout"}, cout8, ec);
        check({tag, "_busy_done"}, busy8, 0);
        $display("op %s: %02h+%02h+%0d -> sum=%02h cout=%0d after %0d cycles", tag, a, b, ci, sum8, cout8, cyc);
        @(negedge clk);
        check({tag, "_done_pulse"}, done8, 0);
    endtask

    task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic ci);
        int cyc;
        logic [2:0] exp;
        exp = 3'(a) + 3'(b) + 3'(ci);
        @(negedge clk);
        start2 = 1'b1; a2 = a; b2 = b; cin2 = ci;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 0;
        while (done2 !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("w2_latency", cyc, 2);
        check("w2_result", {cout2, sum2}, exp);
        $display("w2 op: %0d+%0d+%0d -> cout=%0d sum=%0d", a, b, ci, cout2, sum2);
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) cnt++;
        end
    endtask

    initial begin
        int cyc;
        int nd;
        logic [7:0] ra, rb;
        logic rc;
        logic [8:0] rexp;

        vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy8, 0);
        check("reset_done", done8, 0);
        check("reset_sum", sum8, 0);
        check("reset_cout", cout8, 0);
        check("reset_w2", {busy2, done2, cout2, sum2}, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);

        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            rexp = 9'(ra) + 9'(rb) + 9'(rc);
            run8($sformatf("rnd%0d", i), ra, rb, rc, rexp[7:0], rexp[8]);
        end

        // Start during RUN must be ignored.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0; cyc = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            start8 = (cyc == 2);
            if (cyc == 2) begin a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; end
            @(negedge clk);
            cyc++;
        end
        start8 = 1'b0;
        check("busyprot_latency", cyc, 8);
        check("busyprot_sum", sum8, 8'h30);
        check("busyprot_cout", cout8, 0);
        $display("busy-protection: sum=%02h cout=%0d after %0d cycles", sum8, cout8, cyc);
        count_dones(15, nd);
        check("busyprot_single_done", nd, 0);

        // Reset mid-operation aborts and clears the result.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_busy_before", busy8, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", busy8, 0);
        check("rst_mid_done", done8, 0);
        check("rst_mid_sum", sum8, 0);
        check("rst_mid_cout", cout8, 0);
        $display("reset mid-op: busy=%0d done=%0d sum=%02h cout=%0d", busy8, done8, sum8, cout8);
        count_dones(15, nd);
        check("rst_mid_no_done", nd, 0);
        run8("after_rst", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

        // Back-to-back: start accepted in the DONE cycle.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0; cyc = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_first_latency", cyc, 8);
        check("b2b_first_sum", sum8, 8'h03);
        check("b2b_first_cout", cout8, 0);
        $display("back-to-back first: sum=%02h cout=%0d", sum8, cout8);
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0; cyc = 1;
        check("b2b_busy_no_bubble", busy8, 1);
        while (done8 !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_second_spacing", cyc, 9);
        check("b2b_second_sum", sum8, 8'h00);
        check("b2b_second_cout", cout8, 1);
        $display("back-to-back second: sum=%02h cout=%0d spacing=%0d", sum8, cout8, cyc);

        for (int ia = 0; ia < 4; ia++)
            for (int ib = 0; ib < 4; ib++)
                for (int ic = 0; ic < 2; ic++)
                    run2(2'(ia), 2'(ib), 1'(ic));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
